dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// ============================================================================
// dmem_ctrl : 32-bit data memory, byte/half/word access, post-reset clear sweep
// Option    : DMEM_CTRL_MISALIGN_CHECK_EN rejects misaligned half/word accesses
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_ctrl #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              init_done
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             init_done_q;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;

    logic [31:0]      mem [DEPTH_WORDS];

    logic [IDX_W-1:0] w_idx;
    logic             w_is_byte, w_is_half, w_is_word, w_size_ok;
    logic             w_misalign, w_err, w_accept, w_store;
    logic [1:0]       w_off;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_sh, w_rword, w_rsh, w_load;

    assign w_idx     = req_addr[IDX_W+1:2];
    assign w_is_byte = (req_size[1:0] == 2'b01);
    assign w_is_half = (req_size[1:0] == 2'b10);
    assign w_is_word = (req_size == 3'b011);
    assign w_size_ok = w_is_byte | w_is_half | w_is_word;

`ifdef DMEM_CTRL_MISALIGN_CHECK_EN
    assign w_misalign = (w_is_half & req_addr[0]) | (w_is_word & (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err    = ~w_size_ok | w_misalign;
    assign w_accept = req_valid & (state_q == ST_RUN);
    assign w_store  = w_accept & req_we & ~w_err;

    // Halves and words ignore the low address bits, which force-aligns them.
    assign w_off = w_is_word ? 2'b00 :
                   w_is_half ? {req_addr[1], 1'b0} : req_addr[1:0];
    assign w_be  = w_is_word ? 4'b1111 :
                   w_is_half ? (req_addr[1] ? 4'b1100 : 4'b0011) :
                   (4'b0001 << req_addr[1:0]);

    assign w_wdata_sh = req_wdata << {w_off, 3'b000};
    assign w_rword    = mem[w_idx];
    assign w_rsh      = w_rword >> {w_off, 3'b000};

    always_comb begin
        w_load = w_rsh;
        if (w_is_byte) begin
            w_load = {{24{~req_size[2] & w_rsh[7]}}, w_rsh[7:0]};
        end else if (w_is_half) begin
            w_load = {{16{~req_size[2] & w_rsh[15]}}, w_rsh[15:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= 32'h0;
        end else if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LAST_IDX) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        resp_valid_d = w_accept;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        if (w_accept) begin
            resp_err_d   = w_err;
            resp_rdata_d = (req_we | w_err) ? 32'h0 : w_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            init_done_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_done_q  <= (state_d == ST_RUN);
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == ST_RUN);
    assign init_done  = init_done_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

`default_nettype wire
